fifo_16to8: RTL and testbench

- Single-clock, mixed-width FIFO that buffers 16-bit ADC samples written from the AD7760 parallel bus and returns them as 8-bit bytes.
- Sits between the ADC control state machine (write side, wrreq while DRDY is active) and a byte-oriented consumer such as a UART path (read side).
- Provides independent write-side and read-side status flags and fill counts. Both sides run on the same clock.

---
 rtl/fifo_16to8.sv | 161 ++++++++++++++++
 tb/tb_fifo_16to8.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_16to8.sv
// ---------------------------------------------------------------------------
// fifo_16to8
//   Single-clock mixed-width FIFO. 16-bit ADC words go in on the write side.
//   They come out as 8-bit bytes on the read side, low byte first. The
//   storage is a 256-byte circular buffer, held as 128 words of 16 bits.
//
// Ports
//   clock    in   system clock, all state changes on the rising edge
//   aclr     in   asynchronous active-high clear
//   data     in   [WR_WIDTH-1:0] write word
//   wrreq    in   write request, ignored when wrfull is set
//   rdreq    in   read request, ignored when rdempty is set
//   q        out  [RD_WIDTH-1:0] read byte, valid one clock after an
//                 accepted rdreq and held otherwise
//   wrempty  out  no words occupied
//   wrfull   out  WR_DEPTH words occupied
//   wrusedw  out  occupied words, ceil(bytes/2)
//   rdempty  out  no bytes stored
//   rdfull   out  2*WR_DEPTH bytes stored
//   rdusedw  out  stored bytes modulo 2*WR_DEPTH
// ---------------------------------------------------------------------------
module fifo_16to8 #(
    parameter int WR_WIDTH    = 16,
    parameter int RD_WIDTH    = 8,
    parameter int WR_DEPTH    = 128,
    parameter int USEDW_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic [WR_WIDTH-1:0]    data,
    input  logic                   wrreq,
    input  logic                   rdreq,
    output logic [RD_WIDTH-1:0]    q,
    output logic                   wrempty,
    output logic                   wrfull,
    output logic [USEDW_WIDTH-1:0] wrusedw,
    output logic                   rdempty,
    output logic                   rdfull,
    output logic [USEDW_WIDTH-1:0] rdusedw
);

    localparam int BYTE_DEPTH = 2 * WR_DEPTH;
    localparam int WADDR_W    = $clog2(WR_DEPTH);
    localparam int PTR_W      = WADDR_W + 1;
    localparam int CNT_W      = PTR_W + 1;

    // Word-wide storage. The byte write pointer is always even, so it is
    // kept as a word index. The read pointer is a byte index, and its LSB
    // selects the half of the word.
    logic [WR_WIDTH-1:0]    mem_q [WR_DEPTH];

    logic [WADDR_W-1:0]     wr_word_q, wr_word_d;
    logic [PTR_W-1:0]       rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]       bytes_q,   bytes_d;
    logic [RD_WIDTH-1:0]    q_q,       q_d;

    logic                   wrempty_q, wrempty_d;
    logic                   wrfull_q,  wrfull_d;
    logic [USEDW_WIDTH-1:0] wrusedw_q, wrusedw_d;
    logic                   rdempty_q, rdempty_d;
    logic                   rdfull_q,  rdfull_d;
    logic [USEDW_WIDTH-1:0] rdusedw_q, rdusedw_d;

    logic                   wr_accept;
    logic                   rd_accept;
    logic [WR_WIDTH-1:0]    rd_word;
    logic [RD_WIDTH-1:0]    rd_byte;
    logic [CNT_W-1:0]       words_x2;

    // Both requests are judged against the registered (pre-edge) flags.
    // A word slot that still holds an unread high byte counts as occupied,
    // so wrfull can stay set after one byte has been read.
    always_comb begin
        wr_accept = wrreq & ~wrfull_q;
        rd_accept = rdreq & ~rdempty_q;
    end

    always_comb begin
        rd_word = mem_q[rd_ptr_q[PTR_W-1:1]];
        rd_byte = rd_ptr_q[0] ? rd_word[WR_WIDTH-1:RD_WIDTH]
                              : rd_word[RD_WIDTH-1:0];
    end

    always_comb begin
        wr_word_d = wr_word_q;
        rd_ptr_d  = rd_ptr_q;
        q_d       = q_q;
        bytes_d   = bytes_q;

        if (wr_accept) begin
            wr_word_d = wr_word_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            q_d      = rd_byte;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   bytes_d = bytes_q + CNT_W'(2);
            2'b01:   bytes_d = bytes_q - CNT_W'(1);
            2'b11:   bytes_d = bytes_q + CNT_W'(1);
            default: bytes_d = bytes_q;
        endcase
    end

    // Status is computed from the next byte count and then registered. This
    // keeps every flag and count consistent with the others on each edge.
    always_comb begin
        words_x2  = bytes_d + CNT_W'(1);
        wrusedw_d = USEDW_WIDTH'(words_x2 >> 1);
        wrempty_d = (bytes_d == '0);
        wrfull_d  = ((words_x2 >> 1) == CNT_W'(WR_DEPTH));
        rdusedw_d = USEDW_WIDTH'(bytes_d[PTR_W-1:0]);
        rdempty_d = (bytes_d == '0);
        rdfull_d  = (bytes_d == CNT_W'(BYTE_DEPTH));
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_word_q <= '0;
            rd_ptr_q  <= '0;
            bytes_q   <= '0;
            q_q       <= '0;
            wrempty_q <= 1'b1;
            wrfull_q  <= 1'b0;
            wrusedw_q <= '0;
            rdempty_q <= 1'b1;
            rdfull_q  <= 1'b0;
            rdusedw_q <= '0;
        end else begin
            wr_word_q <= wr_word_d;
            rd_ptr_q  <= rd_ptr_d;
            bytes_q   <= bytes_d;
            q_q       <= q_d;
            wrempty_q <= wrempty_d;
            wrfull_q  <= wrfull_d;
            wrusedw_q <= wrusedw_d;
            rdempty_q <= rdempty_d;
            rdfull_q  <= rdfull_d;
            rdusedw_q <= rdusedw_d;
        end
    end

    // Storage is never reset. The pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (wr_accept && !aclr) begin
            mem_q[wr_word_q] <= data;
        end
    end

    always_comb begin
        q       = q_q;
        wrempty = wrempty_q;
        wrfull  = wrfull_q;
        wrusedw = wrusedw_q;
        rdempty = rdempty_q;
        rdfull  = rdfull_q;
        rdusedw = rdusedw_q;
    end

endmodule

// File: tb/tb_fifo_16to8.sv
module tb_fifo_16to8;

    localparam int WR_DEPTH = 128;

    logic        clock = 1'b0;
    logic        aclr  = 1'b1;
    logic [15:0] data  = '0;
    logic        wrreq = 1'b0;
    logic        rdreq = 1'b0;
    logic [7:0]  q;
    logic        wrempty, wrfull, rdempty, rdfull;
    logic [7:0]  wrusedw, rdusedw;

    fifo_16to8 #(
        .WR_WIDTH   (16),
        .RD_WIDTH   (8),
        .WR_DEPTH   (WR_DEPTH),
        .USEDW_WIDTH(8)
    ) dut (
        .clock  (clock),
        .aclr   (aclr),
        .data   (data),
        .wrreq  (wrreq),
        .rdreq  (rdreq),
        .q      (q),
        .wrempty(wrempty),
        .wrfull (wrfull),
        .wrusedw(wrusedw),
        .rdempty(rdempty),
        .rdfull (rdfull),
        .rdusedw(rdusedw)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rd;
        logic [7:0]  b;
        int unsigned n;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Reference model: a plain byte queue. A write is legal while
    // ceil(bytes/2) < WR_DEPTH. A read is legal while the queue is non-empty.
    // Both are judged on the state before the edge.
    task automatic cyc(input bit w, input bit r, input logic [15:0] d);
        exp_t        e;
        int unsigned n;
        @(negedge clock);
        wrreq = w;
        rdreq = r;
        data  = d;
        n     = ref_q.size();
        e.rd  = r && (n > 0);
        e.b   = '0;
        if (e.rd) e.b = ref_q.pop_front();
        if (w && ((n + 1) / 2) < WR_DEPTH) begin
            ref_q.push_back(d[7:0]);
            ref_q.push_back(d[15:8]);
        end
        e.n = ref_q.size();
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic reset_check(string tag);
        chk({tag, "_q"},       q,       0);
        chk({tag, "_rdempty"}, rdempty, 1);
        chk({tag, "_wrempty"}, wrempty, 1);
        chk({tag, "_rdfull"},  rdfull,  0);
        chk({tag, "_wrfull"},  wrfull,  0);
        chk({tag, "_wrusedw"}, wrusedw, 0);
        chk({tag, "_rdusedw"}, rdusedw, 0);
    endtask

    // Monitor: one expectation per driven cycle, checked just after the edge.
    initial begin
        logic [7:0] last_q;
        exp_t       e;
        last_q = '0;
        forever begin
            @(posedge clock);
            #1;
            if (aclr) begin
                last_q = '0;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.rd) begin
                    last_q = e.b;
                    chk("q_read", q, last_q);
                end else begin
                    chk("q_hold", q, last_q);
                end
                chk("rdusedw", rdusedw, e.n % 256);
                chk("rdempty", rdempty, (e.n == 0) ? 1 : 0);
                chk("rdfull",  rdfull,  (e.n == 256) ? 1 : 0);
                chk("wrusedw", wrusedw, (e.n + 1) / 2);
                chk("wrempty", wrempty, (e.n == 0) ? 1 : 0);
                chk("wrfull",  wrfull,  (((e.n + 1) / 2) == WR_DEPTH) ? 1 : 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pw;
        int pr;

        repeat (2) @(negedge clock);
        reset_check("init");
        aclr = 1'b0;

        // Clear in the middle of a stream after 5 writes
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'($urandom));
        @(negedge clock);
        wrreq = 1'b0;
        rdreq = 1'b0;
        aclr  = 1'b1;
        #1;
        reset_check("midclr");
        ref_q.delete();
        @(negedge clock);
        aclr = 1'b0;
        cyc(1'b0, 1'b1, 16'h0000);
        idle();

        // Single word, low byte first
        cyc(1'b1, 1'b0, 16'hA1B2);
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000);
        idle();

        // Fill to capacity, one write dropped, then drain all 256 bytes
        for (int i = 0; i < WR_DEPTH; i++) cyc(1'b1, 1'b0, 16'(i));
        cyc(1'b1, 1'b0, 16'hFFFF);
        for (int i = 0; i < 256; i++) cyc(1'b0, 1'b1, 16'h0000);
        idle();

        // Odd fill state with three words
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'($urandom));
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000);
        while (ref_q.size() > 0) cyc(1'b0, 1'b1, 16'h0000);
        idle();

        // Write and read together from empty
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 16'($urandom));
        while (ref_q.size() > 0) cyc(1'b0, 1'b1, 16'h0000);
        idle();

        // Many word-in/two-bytes-out cycles so both pointers wrap
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0, 16'($urandom));
            cyc(1'b0, 1'b1, 16'h0000);
            cyc(1'b0, 1'b1, 16'h0000);
        end
        cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000);
        idle();

        // Random traffic that swings between filling and draining
        for (int i = 0; i < 3000; i++) begin
            pw = ((i / 500) % 2 == 0) ? 75 : 25;
            pr = 100 - pw;
            cyc(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
                16'($urandom));
        end
        while (ref_q.size() > 0) cyc(1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b1, 16'h0000);
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
